boot_rst_seq: RTL and testbench

BOOT_RST_SEQ -- requirements
Module: boot_rst_seq

---
 rtl/boot_rst_seq.sv | 139 +++++++++++++
 tb/tb_boot_rst_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/boot_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : boot_rst_seq
// Purpose  : Power-on boot sequencer: lock wait, fabric reset, DMA preload,
//            CPU reset pulse, run, reboot and sticky error handling.
// Revision : 1.0 - initial release
// ============================================================================
module boot_rst_seq #(
   parameter int SYS_DLY    = 200,
   parameter int CPU_DLY    = 200,
   parameter int CPURST_LEN = 10,
   parameter int DMA_TMO    = 65535
) (
   input  logic clk,
   input  logic rstn,
   input  logic clk_locked,
   input  logic dma_done,
   input  logic reboot,
   output logic sys_rstn,
   output logic dma_start,
   output logic cpurst,
   output logic boot_done,
   output logic error
);

   localparam logic [2:0] LOCK     = 3'd0;
   localparam logic [2:0] SYS_WAIT = 3'd1;
   localparam logic [2:0] DMA_KICK = 3'd2;
   localparam logic [2:0] DMA_RUN  = 3'd3;
   localparam logic [2:0] CPU_WAIT = 3'd4;
   localparam logic [2:0] CPU_RST  = 3'd5;
   localparam logic [2:0] RUN      = 3'd6;
   localparam logic [2:0] ERR      = 3'd7;

   // A zero parameter behaves as 1, so the load value is max(P,1)-1.
   localparam logic [15:0] SYS_LD = 16'((SYS_DLY    > 1) ? SYS_DLY    - 1 : 0);
   localparam logic [15:0] CPU_LD = 16'((CPU_DLY    > 1) ? CPU_DLY    - 1 : 0);
   localparam logic [15:0] RST_LD = 16'((CPURST_LEN > 1) ? CPURST_LEN - 1 : 0);
   localparam logic [15:0] DMA_LD = 16'((DMA_TMO    > 1) ? DMA_TMO    - 1 : 0);

   logic [1:0]  rst_sync;
   logic [1:0]  lock_sync;
   logic        rst_ok;
   logic        lock;
   logic [2:0]  state;
   logic [2:0]  state_nxt;
   logic [15:0] cnt;
   logic [15:0] cnt_nxt;
   logic        sys_rstn_d;
   logic        dma_start_d;
   logic        cpurst_d;
   logic        boot_done_d;
   logic        error_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rst_sync  <= 2'b00;
         lock_sync <= 2'b00;
      end else begin
         rst_sync  <= {rst_sync[0], 1'b1};
         lock_sync <= {lock_sync[0], clk_locked};
      end
   end

   assign rst_ok = rst_sync[1];
   assign lock   = lock_sync[1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= LOCK;
         cnt   <= 16'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (rst_ok) begin
         case (state)
            LOCK:     if (lock) state_nxt = SYS_WAIT;
            SYS_WAIT: if (!lock) state_nxt = ERR;
                      else if (cnt == 16'd0) state_nxt = DMA_KICK;
            DMA_KICK: state_nxt = lock ? DMA_RUN : ERR;
            // dma_done on the final count still wins over the timeout
            DMA_RUN:  if (!lock) state_nxt = ERR;
                      else if (dma_done) state_nxt = CPU_WAIT;
                      else if (cnt == 16'd0) state_nxt = ERR;
            CPU_WAIT: if (!lock) state_nxt = ERR;
                      else if (cnt == 16'd0) state_nxt = CPU_RST;
            CPU_RST:  if (!lock) state_nxt = ERR;
                      else if (cnt == 16'd0) state_nxt = RUN;
            RUN:      if (!lock) state_nxt = ERR;
                      else if (reboot) state_nxt = CPU_RST;
            default:  state_nxt = ERR;
         endcase
      end

      cnt_nxt = cnt;
      if (state_nxt != state) begin
         case (state_nxt)
            SYS_WAIT: cnt_nxt = SYS_LD;
            DMA_RUN:  cnt_nxt = DMA_LD;
            CPU_WAIT: cnt_nxt = CPU_LD;
            CPU_RST:  cnt_nxt = RST_LD;
            default:  cnt_nxt = 16'd0;
         endcase
      end else if (cnt != 16'd0) begin
         cnt_nxt = cnt - 16'd1;
      end
   end

   always_comb begin
      sys_rstn_d  = !(state_nxt == LOCK || state_nxt == SYS_WAIT || state_nxt == ERR);
      dma_start_d = (state_nxt == DMA_KICK);
      cpurst_d    = (state_nxt == LOCK || state_nxt == CPU_RST || state_nxt == ERR);
      boot_done_d = (state_nxt == RUN);
      error_d     = (state_nxt == ERR);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sys_rstn  <= 1'b0;
         dma_start <= 1'b0;
         cpurst    <= 1'b1;
         boot_done <= 1'b0;
         error     <= 1'b0;
      end else begin
         sys_rstn  <= sys_rstn_d;
         dma_start <= dma_start_d;
         cpurst    <= cpurst_d;
         boot_done <= boot_done_d;
         error     <= error_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_boot_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_boot_rst_seq
// Purpose  : Randomised boot scenarios against a timeline model of the sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boot_rst_seq;

   localparam int S  = 7;
   localparam int C  = 5;
   localparam int P  = 3;
   localparam int D  = 20;
   localparam int NE = 90;
   localparam int BIG = 1 << 20;

   localparam int PH_LOCK = 0, PH_SYSW = 1, PH_KICK = 2, PH_DRUN = 3;
   localparam int PH_CPUW = 4, PH_CRST = 5, PH_RUN = 6, PH_ERR = 7;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic clk_locked = 1'b0;
   logic dma_done = 1'b0;
   logic reboot = 1'b0;
   logic a_sys_rstn, a_dma_start, a_cpurst, a_boot_done, a_error;
   logic b_sys_rstn, b_dma_start, b_cpurst, b_boot_done, b_error;

   int n_cmp = 0;
   int n_err = 0;

   // scenario: edge indices counted from the first posedge after rstn rises
   int el, ed, ef, er, ea;
   bit ef_on, er_on, ea_on;

   always #5 clk = ~clk;

   boot_rst_seq #(.SYS_DLY(S), .CPU_DLY(C), .CPURST_LEN(P), .DMA_TMO(D)) u_a (
      .clk(clk), .rstn(rstn), .clk_locked(clk_locked), .dma_done(dma_done),
      .reboot(reboot), .sys_rstn(a_sys_rstn), .dma_start(a_dma_start),
      .cpurst(a_cpurst), .boot_done(a_boot_done), .error(a_error));

   boot_rst_seq #(.SYS_DLY(S), .CPU_DLY(0), .CPURST_LEN(0), .DMA_TMO(D)) u_b (
      .clk(clk), .rstn(rstn), .clk_locked(clk_locked), .dma_done(dma_done),
      .reboot(reboot), .sys_rstn(b_sys_rstn), .dma_start(b_dma_start),
      .cpurst(b_cpurst), .boot_done(b_boot_done), .error(b_error));

   task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b {sys_rstn,dma_start,cpurst,boot_done,error}",
                  tag, got, exp);
      end
   endtask

   function automatic int imax(int a, int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int t_sys();
      return imax(3, el + 2);
   endfunction

   function automatic int t_cpuw();
      int k;
      k = t_sys() + S;
      return (ed <= k + D + 1) ? imax(ed, k + 2) : BIG;
   endfunction

   // Phase after edge n, from the timeline rules; cw/pw are effective lengths.
   function automatic int phase(int n, int cw, int pw);
      int k, w, r, run, err_at;
      if (n < t_sys()) return PH_LOCK;
      k = t_sys() + S;
      w = t_cpuw();
      err_at = (w == BIG) ? k + D + 1 : BIG;
      if (ef_on && ef + 2 < err_at) err_at = ef + 2;
      if (n >= err_at) return PH_ERR;
      if (n < k) return PH_SYSW;
      if (n == k) return PH_KICK;
      if (n < w) return PH_DRUN;
      r = w + cw;
      if (n < r) return PH_CPUW;
      run = r + pw;
      if (n < run) return PH_CRST;
      if (er_on && er - 1 >= run && n >= er && n < er + pw) return PH_CRST;
      return PH_RUN;
   endfunction

   function automatic logic [4:0] outs(int ph);
      case (ph)
         PH_LOCK: return 5'b00100;
         PH_SYSW: return 5'b00000;
         PH_KICK: return 5'b11000;
         PH_DRUN: return 5'b10000;
         PH_CPUW: return 5'b10000;
         PH_CRST: return 5'b10100;
         PH_RUN:  return 5'b10010;
         default: return 5'b00101;
      endcase
   endfunction

   function automatic logic [4:0] got_a();
      return {a_sys_rstn, a_dma_start, a_cpurst, a_boot_done, a_error};
   endfunction

   function automatic logic [4:0] got_b();
      return {b_sys_rstn, b_dma_start, b_cpurst, b_boot_done, b_error};
   endfunction

   initial begin
      for (int s = 0; s < 40; s++) begin
         int w_a;
         rstn = 1'b0;
         clk_locked = 1'b0; dma_done = 1'b0; reboot = 1'b0;
         el = int'($urandom_range(1, 6));
         ed = t_sys() + S + 1 + int'($urandom_range(0, D + 2));
         ef_on = ($urandom_range(0, 3) == 0);
         ef = t_sys() + int'($urandom_range(0, 45));
         er_on = ($urandom_range(0, 1) == 0);
         er = t_sys() + int'($urandom_range(20, 70));
         ea_on = ($urandom_range(0, 5) == 0);
         ea = int'($urandom_range(1, 70));
         case (s)
            0: begin ed = t_sys() + S + 11; ef_on = 0; er_on = 0; ea_on = 0; end
            1: begin ed = t_sys() + S + D + 1; ef_on = 0; er_on = 0; ea_on = 0; end
            2: begin ed = BIG; ef_on = 0; er_on = 0; ea_on = 0; end
            3: begin ed = t_sys() + S + 6; ef_on = 1; ef = t_cpuw() + 1; er_on = 0; ea_on = 0; end
            4: begin ed = t_sys() + S + 9; ef_on = 0; er_on = 1; er = t_cpuw() + C + P + 4; ea_on = 0; end
            5: begin ed = t_sys() + S + 9; ef_on = 0; er_on = 1; er = t_cpuw() + 2; ea_on = 0; end
            6: begin ed = t_sys() + S + 4; ef_on = 0; er_on = 0; ea_on = 1; ea = t_cpuw() + C + 1; end
            default: ;
         endcase
         w_a = t_cpuw();
         repeat (2) @(negedge clk);
         check($sformatf("s%0d/rst/A", s), got_a(), 5'b00100);
         check($sformatf("s%0d/rst/B", s), got_b(), 5'b00100);
         for (int n = 1; n <= NE; n++) begin
            if (n > 1) @(negedge clk);
            clk_locked = (n >= el) && !(ef_on && n >= ef && n < ef + 5);
            dma_done   = (n >= ed);
            reboot     = er_on && (n == er);
            rstn       = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("s%0d/n%0d/A w=%0d", s, n, w_a), got_a(), outs(phase(n, C, P)));
            check($sformatf("s%0d/n%0d/B w=%0d", s, n, w_a), got_b(), outs(phase(n, 1, 1)));
            if (ea_on && n == ea) begin
               #2 rstn = 1'b0;
               #1;
               check($sformatf("s%0d/abort/A", s), got_a(), 5'b00100);
               check($sformatf("s%0d/abort/B", s), got_b(), 5'b00100);
               break;
            end
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
